pi_port_arbiter: RTL and testbench

Packet-aware round-robin arbiter that shares one pi-switch output port between up to N_IN competing input streams. It sits between the per-input buffers of a pi switch and one output link (l, r, u0 or u1). It locks a grant from the first beat of a packet until its wlast beat (wormhole), and drives the output through a one-entry registered stage with ready/valid backpressure.

---
 rtl/pi_port_arbiter_if.sv | 45 ++++
 rtl/pi_port_arbiter.sv | 156 +++++++++++++++
 tb/tb_pi_port_arbiter.sv | 207 ++++++++++++++++++++
 3 files changed

// File: rtl/pi_port_arbiter_if.sv
// rtl/pi_port_arbiter_if.sv - bus bundle between the input buffers, the arbiter and one output link
//
// Purpose: carries every handshake/data signal of pi_port_arbiter.
//   master : arbiter side (drives s_wready, the output beat and the status).
//   slave  : environment side (input buffers plus the downstream link).
// Signals:
//   s_wdata  [N_IN*PW] input beats, input i at [i*PW +: PW]
//   s_wvalid [N_IN]    per-input beat valid
//   s_wlast  [N_IN]    per-input last beat of packet
//   s_wready [N_IN]    per-input accept, at most one bit high
//   m_wdata  [PW]      registered output beat
//   m_wvalid           output valid
//   m_wlast            output last-beat flag
//   m_wready           downstream accept
//   owner    [OW]      locked input, or the last winner
//   locked             high while a multi-beat packet is mid-flight
interface pi_port_arbiter_if #(
    parameter int N_IN = 3,
    parameter int A_W  = 2,
    parameter int D_W  = 32
);
    localparam int PW = A_W + D_W;
    localparam int OW = (N_IN > 1) ? $clog2(N_IN) : 1;

    logic [N_IN*PW-1:0] s_wdata;
    logic [N_IN-1:0]    s_wvalid;
    logic [N_IN-1:0]    s_wlast;
    logic [N_IN-1:0]    s_wready;
    logic [PW-1:0]      m_wdata;
    logic               m_wvalid;
    logic               m_wlast;
    logic               m_wready;
    logic [OW-1:0]      owner;
    logic               locked;

    modport master (
        input  s_wdata, s_wvalid, s_wlast, m_wready,
        output s_wready, m_wdata, m_wvalid, m_wlast, owner, locked
    );

    modport slave (
        output s_wdata, s_wvalid, s_wlast, m_wready,
        input  s_wready, m_wdata, m_wvalid, m_wlast, owner, locked
    );
endinterface

// File: rtl/pi_port_arbiter.sv
// rtl/pi_port_arbiter.sv - packet-aware round-robin arbiter for one pi-switch output port
//
// Purpose: shares one output link between N_IN input streams. A grant is
//   locked from the first beat of a packet until its wlast beat (wormhole);
//   the output goes through a one-entry registered stage with ready/valid.
// Ports:
//   clk  clock
//   rst  synchronous, active-high reset
//   bus  pi_port_arbiter_if.master (s_wdata/s_wvalid/s_wlast/s_wready in,
//        m_wdata/m_wvalid/m_wlast/m_wready out, owner, locked)
module pi_port_arbiter #(
    parameter int N_IN = 3,
    parameter int A_W  = 2,
    parameter int D_W  = 32
) (
    input  logic                 clk,
    input  logic                 rst,
    pi_port_arbiter_if.master    bus
);
    localparam int PW = A_W + D_W;
    localparam int OW = (N_IN > 1) ? $clog2(N_IN) : 1;

    typedef enum logic {
        IDLE   = 1'b0,
        LOCKED = 1'b1
    } state_t;

    state_t          state_q, state_d;
    logic [OW-1:0]   ptr_q, ptr_d;
    logic [OW-1:0]   owner_q, owner_d;
    logic [PW-1:0]   data_q, data_d;
    logic            valid_q, valid_d;
    logic            last_q, last_d;

    logic            slot_free;
    logic            found;
    logic [OW-1:0]   winner;
    logic [OW-1:0]   grant_idx;
    logic            grant_en;
    logic [N_IN-1:0] ready;
    logic            accept;
    logic            grant_last;
    logic [PW-1:0]   grant_data;

    // Round-robin successor; explicit wrap because N_IN need not be a power of two.
    function automatic logic [OW-1:0] inc_wrap(input logic [OW-1:0] v);
        if (int'(v) == N_IN - 1) begin
            return '0;
        end
        return v + 1'b1;
    endfunction

    assign slot_free = ~valid_q | bus.m_wready;

    // First valid input scanning ptr, ptr+1, ... modulo N_IN.
    always_comb begin
        int            idx;
        logic [OW-1:0] idx_v;
        found  = 1'b0;
        winner = '0;
        idx    = 0;
        idx_v  = '0;
        for (int k = 0; k < N_IN; k++) begin
            idx = int'(ptr_q) + k;
            if (idx >= N_IN) begin
                idx = idx - N_IN;
            end
            idx_v = OW'(idx);
            if (!found && bus.s_wvalid[idx_v]) begin
                found  = 1'b1;
                winner = idx_v;
            end
        end
    end

    // While locked only the owner may be granted; other valids are ignored,
    // so the grant cannot migrate across a mid-packet bubble.
    assign grant_idx = (state_q == LOCKED) ? owner_q : winner;
    assign grant_en  = (state_q == LOCKED) ? 1'b1 : found;

    always_comb begin
        ready = '0;
        if (!rst && grant_en && slot_free) begin
            ready[grant_idx] = 1'b1;
        end
    end

    assign accept     = |(ready & bus.s_wvalid);
    assign grant_last = bus.s_wlast[grant_idx];
    assign grant_data = bus.s_wdata[grant_idx*PW +: PW];

    always_comb begin
        state_d = state_q;
        ptr_d   = ptr_q;
        owner_d = owner_q;
        data_d  = data_q;
        valid_d = valid_q;
        last_d  = last_q;

        case (state_q)
            IDLE: begin
                if (accept) begin
                    owner_d = winner;
                    if (grant_last) begin
                        ptr_d = inc_wrap(winner);
                    end else begin
                        state_d = LOCKED;
                    end
                end
            end
            LOCKED: begin
                if (accept && grant_last) begin
                    state_d = IDLE;
                    ptr_d   = inc_wrap(owner_q);
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        // Output stage: load on accept, drain on m_wready, otherwise hold.
        if (accept) begin
            data_d  = grant_data;
            last_d  = grant_last;
            valid_d = 1'b1;
        end else if (bus.m_wready) begin
            valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            ptr_q   <= '0;
            owner_q <= '0;
            data_q  <= '0;
            valid_q <= 1'b0;
            last_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            owner_q <= owner_d;
            data_q  <= data_d;
            valid_q <= valid_d;
            last_q  <= last_d;
        end
    end

    assign bus.s_wready = ready;
    assign bus.m_wdata  = data_q;
    assign bus.m_wvalid = valid_q;
    assign bus.m_wlast  = last_q;
    assign bus.owner    = owner_q;
    assign bus.locked   = (state_q == LOCKED);
endmodule

// File: tb/tb_pi_port_arbiter.sv
// tb/tb_pi_port_arbiter.sv - directed self-checking bench for pi_port_arbiter
module tb_pi_port_arbiter;
    localparam int N_IN = 3;
    localparam int A_W  = 2;
    localparam int D_W  = 32;
    localparam int PW   = A_W + D_W;

    logic clk = 1'b0;
    logic rst;
    int   checks   = 0;
    int   failures = 0;

    always #5 clk = ~clk;

    pi_port_arbiter_if #(.N_IN(N_IN), .A_W(A_W), .D_W(D_W)) bus ();

    pi_port_arbiter #(.N_IN(N_IN), .A_W(A_W), .D_W(D_W)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
        end
    endtask

    function automatic logic [PW-1:0] beat(input int i, input logic [31:0] d);
        logic [A_W-1:0] a;
        a = A_W'(i);
        return {a, d};
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input int i, input logic v, input logic l, input logic [31:0] d);
        bus.s_wvalid[i]            = v;
        bus.s_wlast[i]             = l;
        bus.s_wdata[i*PW +: PW]    = beat(i, d);
    endtask

    initial begin
        rst          = 1'b1;
        bus.s_wdata  = '0;
        bus.s_wvalid = '0;
        bus.s_wlast  = '0;
        bus.m_wready = 1'b1;

        // Reset state; ready gated during reset even with a valid input.
        tick();
        drive(0, 1'b1, 1'b1, 32'h1);
        #1;
        check("rst_ready_gated", 64'(bus.s_wready), 64'h0);
        rst = 1'b0;
        drive(0, 1'b0, 1'b0, 32'h0);
        #1;
        check("rst_m_wvalid", 64'(bus.m_wvalid), 64'h0);
        check("rst_m_wdata",  64'(bus.m_wdata),  64'h0);
        check("rst_m_wlast",  64'(bus.m_wlast),  64'h0);
        check("rst_owner",    64'(bus.owner),    64'h0);
        check("rst_locked",   64'(bus.locked),   64'h0);
        check("rst_ready",    64'(bus.s_wready), 64'h0);

        // 4-beat packet on input 1.
        for (int b = 0; b < 4; b++) begin
            drive(1, 1'b1, (b == 3), 32'h10 + b);
            #1;
            check("pkt1_ready",      64'(bus.s_wready), 64'b010);
            check("pkt1_locked_pre", 64'(bus.locked),   64'(b > 0));
            tick();
            check("pkt1_m_wdata",  64'(bus.m_wdata),  64'(beat(1, 32'h10 + b)));
            check("pkt1_m_wvalid", 64'(bus.m_wvalid), 64'h1);
            check("pkt1_m_wlast",  64'(bus.m_wlast),  64'(b == 3));
            check("pkt1_locked",   64'(bus.locked),   64'(b < 3));
            check("pkt1_owner",    64'(bus.owner),    64'h1);
        end
        drive(1, 1'b0, 1'b0, 32'h0);

        // ptr should now be 2: with all inputs valid, input 2 wins.
        for (int i = 0; i < N_IN; i++) drive(i, 1'b1, 1'b1, 32'h100 + i);
        #1;
        check("ptr_after_pkt1", 64'(bus.s_wready), 64'b100);

        // Continuous single-beat requests from all inputs after reset: 0,1,2,0,1,2.
        rst = 1'b1;
        tick();
        rst = 1'b0;
        for (int g = 0; g < 6; g++) begin
            #1;
            check("rr_ready", 64'(bus.s_wready), 64'(1 << (g % 3)));
            tick();
            check("rr_m_wvalid", 64'(bus.m_wvalid), 64'h1);
            check("rr_m_wdata",  64'(bus.m_wdata),  64'(beat(g % 3, 32'h100 + (g % 3))));
        end
        for (int i = 0; i < N_IN; i++) drive(i, 1'b0, 1'b0, 32'h0);

        // Input 0 3-beat packet with a bubble; input 2 valid throughout.
        drive(0, 1'b1, 1'b0, 32'h30);
        drive(2, 1'b1, 1'b1, 32'h200);
        #1;
        check("wh_ready_b1", 64'(bus.s_wready), 64'b001);
        tick();
        check("wh_locked_b1", 64'(bus.locked),  64'h1);
        check("wh_owner_b1",  64'(bus.owner),   64'h0);
        check("wh_data_b1",   64'(bus.m_wdata), 64'(beat(0, 32'h30)));
        drive(0, 1'b0, 1'b0, 32'h30);
        #1;
        check("wh_bubble_r2", 64'(bus.s_wready[2]), 64'h0);
        tick();
        check("wh_bubble_nov", 64'(bus.m_wvalid), 64'h0);
        check("wh_bubble_lck", 64'(bus.locked),   64'h1);
        drive(0, 1'b1, 1'b0, 32'h31);
        #1;
        check("wh_ready_b2", 64'(bus.s_wready), 64'b001);
        tick();
        check("wh_data_b2", 64'(bus.m_wdata), 64'(beat(0, 32'h31)));
        drive(0, 1'b1, 1'b1, 32'h32);
        #1;
        check("wh_ready_b3", 64'(bus.s_wready), 64'b001);
        tick();
        check("wh_data_b3",   64'(bus.m_wdata), 64'(beat(0, 32'h32)));
        check("wh_last_b3",   64'(bus.m_wlast), 64'h1);
        check("wh_unlocked",  64'(bus.locked),  64'h0);
        drive(0, 1'b0, 1'b0, 32'h0);
        #1;
        check("wh_next_r2", 64'(bus.s_wready), 64'b100);
        tick();
        check("wh_next_data", 64'(bus.m_wdata), 64'(beat(2, 32'h200)));
        drive(2, 1'b0, 1'b0, 32'h0);

        // Backpressure: 0xAA pending for 5 cycles with m_wready low.
        drive(1, 1'b1, 1'b1, 32'hAA);
        #1;
        check("bp_ready_aa", 64'(bus.s_wready), 64'b010);
        tick();
        drive(1, 1'b0, 1'b0, 32'h0);
        drive(0, 1'b1, 1'b1, 32'hBB);
        bus.m_wready = 1'b0;
        for (int c = 0; c < 5; c++) begin
            #1;
            check("bp_ready_zero", 64'(bus.s_wready), 64'h0);
            check("bp_hold_data",  64'(bus.m_wdata),  64'(beat(1, 32'hAA)));
            check("bp_hold_valid", 64'(bus.m_wvalid), 64'h1);
            tick();
        end
        bus.m_wready = 1'b1;
        #1;
        check("bp_release_ready", 64'(bus.s_wready), 64'b001);
        tick();
        check("bp_next_data", 64'(bus.m_wdata), 64'(beat(0, 32'hBB)));
        drive(0, 1'b0, 1'b0, 32'h0);
        tick();
        check("bp_drained", 64'(bus.m_wvalid), 64'h0);

        // Reset during beat 2 of a 4-beat packet from input 1 (ptr is 1 here).
        drive(1, 1'b1, 1'b0, 32'h50);
        #1;
        check("mr_ready_b1", 64'(bus.s_wready), 64'b010);
        tick();
        drive(1, 1'b1, 1'b0, 32'h51);
        rst = 1'b1;
        #1;
        check("mr_ready_in_rst", 64'(bus.s_wready), 64'h0);
        tick();
        rst = 1'b0;
        drive(1, 1'b0, 1'b0, 32'h0);
        drive(0, 1'b1, 1'b1, 32'hC0);
        drive(2, 1'b1, 1'b1, 32'hC2);
        check("mr_m_wvalid", 64'(bus.m_wvalid), 64'h0);
        check("mr_m_wdata",  64'(bus.m_wdata),  64'h0);
        check("mr_m_wlast",  64'(bus.m_wlast),  64'h0);
        check("mr_locked",   64'(bus.locked),   64'h0);
        check("mr_owner",    64'(bus.owner),    64'h0);
        #1;
        check("mr_first_grant", 64'(bus.s_wready), 64'b001);
        tick();
        check("mr_first_data", 64'(bus.m_wdata), 64'(beat(0, 32'hC0)));

        // Bring ptr to 2, then check the wrap with only inputs 0 and 2 valid.
        drive(0, 1'b0, 1'b0, 32'h0);
        drive(2, 1'b0, 1'b0, 32'h0);
        drive(1, 1'b1, 1'b1, 32'hD1);
        #1;
        check("wrap_setup", 64'(bus.s_wready), 64'b010);
        tick();
        drive(1, 1'b0, 1'b0, 32'h0);
        drive(0, 1'b1, 1'b1, 32'hE0);
        drive(2, 1'b1, 1'b1, 32'hE2);
        #1;
        check("wrap_ptr2_win", 64'(bus.s_wready), 64'b100);
        tick();
        check("wrap_data2", 64'(bus.m_wdata), 64'(beat(2, 32'hE2)));
        #1;
        check("wrap_ptr0_win", 64'(bus.s_wready), 64'b001);
        tick();
        check("wrap_data0", 64'(bus.m_wdata), 64'(beat(0, 32'hE0)));

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
